// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit:
// opcodes, funct fields, ALU op codes and FSM/decode enumerations.
package ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_sel_t;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BEQ, K_BNE, K_ILL} kind_t;

  // funct3 values shared by the register and immediate logic/add groups
  function automatic logic is_alu_f3(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate selection (I/S/B) and sign extension to XLEN.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        sel,
  output logic [XLEN-1:0] imm
);

  logic [12:0] raw;
  logic        unused_bits;

  assign unused_bits = ^{instr[19:12], instr[6:0]};

  always_comb begin
    raw = '0;
    case (sel)
      IMM_I:   raw = {instr[31], instr[31:20]};
      IMM_S:   raw = {instr[31], instr[31:25], instr[11:7]};
      IMM_B:   raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I-subset control unit. Optional macro CTRL_MC_ILLEGAL_TRAP_EN
// makes illegal instructions halt the controller instead of retiring as a NOP.
//
//  state  | meaning
//  IDLE   | instr_ready high, waiting for a handshake
//  DECODE | latched instruction decoded into output registers
//  EXEC   | ALU / branch completion, or launch of a memory access
//  MEM    | mem_re / mem_we held for MEM_LAT cycles
//  WB     | load data written back to the register file
//  HALT   | illegal instruction trapped, left only via rst
module ctrl_mc
  import ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            alu_zero,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      alu_op,
  output logic            has_imm,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            mem_re,
  output logic            mem_we,
  output logic            pc_we,
  output logic            pc_branch,
  output logic            retire,
  output logic            illegal
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t          state, state_nxt;
  logic [31:0]     ir;
  logic [CW-1:0]   mem_cnt;
  logic            mem_last;
  kind_t           kind_q, kind_d;
  logic [2:0]      alu_op_d;
  logic            has_imm_d;
  imm_sel_t        imm_sel_d;
  logic [XLEN-1:0] imm_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  always_comb begin
    kind_d    = K_ILL;
    alu_op_d  = ALU_NONE;
    has_imm_d = 1'b0;
    imm_sel_d = IMM_NONE;
    case (opc)
      OP_IMM: if (is_alu_f3(f3)) begin
        kind_d    = K_ALU;
        alu_op_d  = (f3 == F3_ADD) ? ALU_ADD : f3;
        has_imm_d = 1'b1;
        imm_sel_d = IMM_I;
      end
      OP_REG: begin
        if (is_alu_f3(f3) && f7 == F7_BASE) begin
          kind_d   = K_ALU;
          alu_op_d = (f3 == F3_ADD) ? ALU_ADD : f3;
        end else if (f3 == F3_ADD && f7 == F7_SUB) begin
          kind_d   = K_ALU;
          alu_op_d = ALU_SUB;
        end
      end
      OP_LOAD: if (f3 == F3_W) begin
        kind_d    = K_LOAD;
        alu_op_d  = ALU_ADD;
        has_imm_d = 1'b1;
        imm_sel_d = IMM_I;
      end
      OP_STORE: if (f3 == F3_W) begin
        kind_d    = K_STORE;
        alu_op_d  = ALU_ADD;
        has_imm_d = 1'b1;
        imm_sel_d = IMM_S;
      end
      OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin
        kind_d    = (f3 == F3_BEQ) ? K_BEQ : K_BNE;
        alu_op_d  = ALU_SUB;
        imm_sel_d = IMM_B;
      end
      default: kind_d = K_ILL;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (ir),
    .sel   (imm_sel_d),
    .imm   (imm_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ir <= '0;
    else if (instr_valid && instr_ready)  ir <= instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      imm     <= '0;
      alu_op  <= ALU_NONE;
      has_imm <= 1'b0;
      wb_sel  <= 1'b0;
      kind_q  <= K_ALU;
    end else if (state == DECODE) begin
      rs1     <= ir[19:15];
      rs2     <= ir[24:20];
      rd      <= ir[11:7];
      imm     <= imm_d;
      alu_op  <= alu_op_d;
      has_imm <= has_imm_d;
      wb_sel  <= (kind_d == K_LOAD);
      kind_q  <= kind_d;
    end
  end

  // Down-counter loaded on the way into MEM; terminal count marks the last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                mem_cnt <= '0;
    else if (state == EXEC)                 mem_cnt <= CW'(MEM_LAT - 1);
    else if (state == MEM && mem_cnt != '0) mem_cnt <= mem_cnt - CW'(1);
  end

  assign mem_last = (mem_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (instr_valid) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        case (kind_q)
          K_LOAD, K_STORE: state_nxt = MEM;
`ifdef CTRL_MC_ILLEGAL_TRAP_EN
          K_ILL:           state_nxt = HALT;
`else
          K_ILL:           state_nxt = IDLE;
`endif
          default:         state_nxt = IDLE;
        endcase
      end
      MEM:    if (mem_last) state_nxt = (kind_q == K_LOAD) ? WB : IDLE;
      WB:     state_nxt = IDLE;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && !rst;
    rf_we       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    pc_branch   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state)
      EXEC: begin
        case (kind_q)
          K_ALU: begin
            rf_we  = (rd != 5'd0);
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          K_BEQ, K_BNE: begin
            pc_we     = 1'b1;
            pc_branch = (kind_q == K_BEQ) ? alu_zero : !alu_zero;
            retire    = 1'b1;
          end
          K_ILL: begin
            illegal = 1'b1;
`ifndef CTRL_MC_ILLEGAL_TRAP_EN
            pc_we   = 1'b1;
            retire  = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_re = (kind_q == K_LOAD);
        mem_we = (kind_q == K_STORE);
        if (mem_last && kind_q == K_STORE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      WB: begin
        rf_we  = (rd != 5'd0);
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      HALT: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed scoreboard bench for ctrl_mc: expected retire records are queued at
// issue and popped when the DUT pulses retire.
module tb_ctrl_mc;

  localparam int XLEN    = 32;
  localparam int MEM_LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            alu_zero;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      alu_op;
  logic            has_imm, rf_we, wb_sel, mem_re, mem_we, pc_we, pc_branch, retire, illegal;
  logic [63:0]     outs;

  always #5 clk = ~clk;

  ctrl_mc #(.XLEN(XLEN), .MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_zero    (alu_zero),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .imm         (imm),
    .alu_op      (alu_op),
    .has_imm     (has_imm),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .pc_we       (pc_we),
    .pc_branch   (pc_branch),
    .retire      (retire),
    .illegal     (illegal)
  );

  assign outs = {3'b000, instr_ready, rs1, rs2, rd, imm, alu_op, has_imm, rf_we,
                 wb_sel, mem_re, mem_we, pc_we, pc_branch, retire, illegal};

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        chk_imm;
    logic [2:0]  alu_op;
    logic        has_imm;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_branch;
    logic        illegal;
    int          lat;
    int          n_re;
    int          n_we;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rd_e, input logic [31:0] imm_e, input logic ci,
                              input logic [2:0] op_e, input logic hi, input logic we,
                              input logic wb, input logic br, input logic il,
                              input int lat, input int nre, input int nwe);
    exp_t e;
    e.rd = rd_e; e.imm = imm_e; e.chk_imm = ci; e.alu_op = op_e; e.has_imm = hi;
    e.rf_we = we; e.wb_sel = wb; e.pc_branch = br; e.illegal = il;
    e.lat = lat; e.n_re = nre; e.n_we = nwe;
    return e;
  endfunction

  task automatic issue(input string tag, input logic [31:0] word, input logic zero, input exp_t e);
    exp_t got;
    int n_re = 0, n_we = 0, n_rf = 0, n_pc = 0, n_ret = 0, ret_c = 0;
    exp_q.push_back(e);
    @(negedge clk);
    alu_zero    = zero;
    instr       = word;
    instr_valid = 1'b1;
    check({tag, ".ready"}, 64'(instr_ready), 64'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ret_c != 0) begin
        check({tag, ".ready_after"}, 64'(instr_ready), 64'd1);
        break;
      end
      if (mem_re) n_re++;
      if (mem_we) n_we++;
      if (rf_we)  n_rf++;
      if (pc_we)  n_pc++;
      if (retire) n_ret++;
      if (retire) begin
        ret_c = c;
        got   = exp_q.pop_front();
        check({tag, ".latency"}, 64'(ret_c), 64'(got.lat));
        check({tag, ".rd"}, 64'(rd), 64'(got.rd));
        if (got.chk_imm) check({tag, ".imm"}, 64'(imm), 64'(got.imm));
        check({tag, ".alu_op"}, 64'(alu_op), 64'(got.alu_op));
        check({tag, ".has_imm"}, 64'(has_imm), 64'(got.has_imm));
        check({tag, ".rf_we"}, 64'(rf_we), 64'(got.rf_we));
        check({tag, ".wb_sel"}, 64'(wb_sel), 64'(got.wb_sel));
        check({tag, ".pc_we"}, 64'(pc_we), 64'd1);
        check({tag, ".pc_branch"}, 64'(pc_branch), 64'(got.pc_branch));
        check({tag, ".illegal"}, 64'(illegal), 64'(got.illegal));
      end
    end
    if (ret_c == 0) begin
      check({tag, ".retire_seen"}, 64'd0, 64'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    check({tag, ".n_mem_re"}, 64'(n_re), 64'(e.n_re));
    check({tag, ".n_mem_we"}, 64'(n_we), 64'(e.n_we));
    check({tag, ".n_rf_we"}, 64'(n_rf), 64'(e.rf_we));
    check({tag, ".n_pc_we"}, 64'(n_pc), 64'd1);
    check({tag, ".n_retire"}, 64'(n_ret), 64'd1);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    alu_zero    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outs", outs, 64'd0);
    instr_valid = 1'b1;
    #1;
    check("reset.ready_low", 64'(instr_ready), 64'd0);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    issue("addi", 32'h00500093, 1'b0, mk(5'd1, 32'd5, 1, 3'b001, 1, 1, 0, 0, 0, 2, 0, 0));
    issue("add_x0", 32'h00208033, 1'b0, mk(5'd0, 32'd0, 0, 3'b001, 0, 0, 0, 0, 0, 2, 0, 0));
    issue("sub", 32'h402081B3, 1'b0, mk(5'd3, 32'd0, 0, 3'b010, 0, 1, 0, 0, 0, 2, 0, 0));
    issue("xori", 32'hFFF0C293, 1'b0, mk(5'd5, 32'hFFFFFFFF, 1, 3'b100, 1, 1, 0, 0, 0, 2, 0, 0));
    issue("and", 32'h0020F333, 1'b0, mk(5'd6, 32'd0, 0, 3'b111, 0, 1, 0, 0, 0, 2, 0, 0));
    issue("addi_x0_min", 32'h80000013, 1'b0, mk(5'd0, 32'hFFFFF800, 1, 3'b001, 1, 0, 0, 0, 0, 2, 0, 0));
    issue("sw", 32'h0020A423, 1'b0, mk(5'd8, 32'd8, 1, 3'b001, 1, 0, 0, 0, 0, 2 + MEM_LAT, 0, MEM_LAT));
    issue("lw", 32'hFFC0A203, 1'b0, mk(5'd4, 32'hFFFFFFFC, 1, 3'b001, 1, 1, 1, 0, 0, 3 + MEM_LAT, MEM_LAT, 0));
    issue("beq_t", 32'hFE208CE3, 1'b1, mk(5'd25, 32'hFFFFFFF8, 1, 3'b010, 0, 0, 0, 1, 0, 2, 0, 0));
    issue("beq_nt", 32'hFE208CE3, 1'b0, mk(5'd25, 32'hFFFFFFF8, 1, 3'b010, 0, 0, 0, 0, 0, 2, 0, 0));
    issue("bne_t", 32'hFE209CE3, 1'b0, mk(5'd25, 32'hFFFFFFF8, 1, 3'b010, 0, 0, 0, 1, 0, 2, 0, 0));
    issue("bne_nt", 32'hFE209CE3, 1'b1, mk(5'd25, 32'hFFFFFFF8, 1, 3'b010, 0, 0, 0, 0, 0, 2, 0, 0));

`ifdef CTRL_MC_ILLEGAL_TRAP_EN
    @(negedge clk);
    instr       = 32'hFFFFFFFF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("trap.illegal_exec", 64'(illegal), 64'd1);
    check("trap.no_retire", 64'(retire), 64'd0);
    repeat (4) @(negedge clk);
    check("trap.halt", {illegal, instr_ready, retire, pc_we, rf_we}, 64'b10000);
    rst = 1'b1;
    #1;
    check("trap.reset", outs, 64'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    issue("illegal", 32'hFFFFFFFF, 1'b0, mk(5'd31, 32'd0, 0, 3'b000, 0, 0, 0, 0, 1, 2, 0, 0));
    @(negedge clk);
    check("illegal.one_cycle", 64'(illegal), 64'd0);
`endif

    @(negedge clk);
    instr       = 32'hFFC0A203;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_lw.in_mem", 64'(mem_re), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_lw.outs", outs, 64'd0);
    @(negedge clk);
    check("rst_mid_lw.held", outs, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_lw.ready", 64'(instr_ready), 64'd1);

    issue("addi_after_rst", 32'h00500093, 1'b0, mk(5'd1, 32'd5, 1, 3'b001, 1, 1, 0, 0, 0, 2, 0, 0));
    check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
Multi-cycle RV32I-subset control unit. It succeeds the single-cycle combinational decoder.
- Accepts one instruction per valid/ready handshake and registers it.
- Sequences it through a decode/execute/memory/writeback FSM, issuing datapath strobes per cycle.
- Adds SUB, LW, SW, BEQ, BNE, configurable memory latency, x0 write suppression and illegal-instruction reporting.
- Sits between the instruction fetch port and the register file, ALU and data memory.

Parameters:
- XLEN, 32: width of the sign-extended immediate output; must be at least 13.
- MEM_LAT, 1: cycles that mem_re/mem_we are held in MEM; must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  fetch has an instruction on instr
- instr  in  32  instruction word
- instr_ready  out  1  = (state==IDLE) && !rst; handshake occurs when valid&&ready at a clk edge
- alu_zero  in  1  ALU result==0, sampled in EXEC for branches
- rs1, rs2, rd  out  5 each  register indices from the latched instruction
- imm  out  XLEN  sign-extended immediate
- alu_op  out  3  000 none, 001 add, 010 sub, 100 xor, 110 or, 111 and
- has_imm  out  1  ALU operand B is imm
- rf_we  out  1  register file write strobe
- wb_sel  out  1  0: write back ALU result; 1: write back memory data
- mem_re, mem_we  out  1 each  data memory read / write enables
- pc_we  out  1  advance PC this cycle
- pc_branch  out  1  with pc_we: PC += imm, otherwise PC += 4
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  unsupported encoding detected

Behaviour:
- Reset: state=IDLE, IR=0, MEM counter=0. All outputs are 0 while rst is high, including instr_ready. Reset asserted mid-instruction aborts it with no further strobes.
- IDLE: instr_ready=1. On handshake, instr is latched into IR and the FSM goes to DECODE.
- DECODE (1 cycle): registers rs1/rs2/rd/imm/alu_op/has_imm/wb_sel from IR. These hold until the next handshake; no strobes in this cycle.
- Decode table (opcode / funct3 / instr[31:25]):
  - 0010011 / 000,100,110,111 / any: ADDI, XORI, ORI, ANDI; alu_op = 001, 100, 110, 111; has_imm=1; I-immediate.
  - 0110011 / 000,100,110,111 / 0000000: ADD, XOR, OR, AND with the same alu_op values; has_imm=0.
  - 0110011 / 000 / 0100000: SUB; alu_op=010.
  - 0000011 / 010: LW; add, has_imm=1, I-immediate.
  - 0100011 / 010: SW; add, has_imm=1, S-immediate {[31:25],[11:7]}.
  - 1100011 / 000 (BEQ) or 001 (BNE): sub, has_imm=0, B-immediate {[31],[7],[30:25],[11:8],0}.
  - Anything else is illegal.
- Immediates are sign-extended to XLEN.
- EXEC (1 cycle):
  - ALU ops: rf_we=(rd!=0), pc_we=1, retire=1, then IDLE.
  - LW/SW: go to MEM.
  - Branch: taken = alu_zero for BEQ, !alu_zero for BNE; pc_we=1, pc_branch=taken, retire=1, then IDLE.
- MEM: mem_re (LW) or mem_we (SW) is held for exactly MEM_LAT cycles, counted by the MEM counter.
  - SW: pc_we=1 and retire=1 in the last MEM cycle, then IDLE.
  - LW: go to WB.
- WB (LW only, 1 cycle): rf_we=(rd!=0), wb_sel=1, pc_we=1, retire=1, then IDLE.
- Latency from handshake edge to retire cycle: ALU/branch 2; SW 2+MEM_LAT; LW 3+MEM_LAT. At most one instruction in flight.
- Writes to x0 decode normally and retire normally, but rf_we stays 0.

Optional Feature:
- Macro: CTRL_MC_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction enters HALT from EXEC. In HALT, illegal is held at 1, instr_ready=0, and no strobes or retire are issued; only rst exits HALT.
- Undefined: an illegal instruction executes as a NOP. In EXEC: illegal=1 for one cycle, pc_we=1, retire=1, no rf_we/mem strobes, then IDLE.

Decomposition:
- Package ctrl_pkg: opcode and funct3/funct7 constants, alu_op encodings, FSM state typedef (IDLE, DECODE, EXEC, MEM, WB, HALT).
- Sub-module imm_gen: combinational I/S/B immediate selection and sign extension, parameterised by XLEN.

Test Plan:
- ADDI x1,x0,5 (0x00500093) → 2 cycles after handshake: rf_we=1, rd=1, imm=5, alu_op=001, has_imm=1, pc_we=1, retire=1.
- ADD x0,x1,x2 (0x00208033) → alu_op=001, has_imm=0, retire=1, rf_we stays 0.
- SW x2,8(x1) (0x0020A423), MEM_LAT=3 → imm=8; mem_we high for exactly 3 cycles; retire in the 3rd; rf_we never asserted.
- LW x4,-4(x1) (0xFFC0A203), MEM_LAT=1 → imm=0xFFFFFFFC; mem_re for 1 cycle, then WB with rf_we=1, wb_sel=1, retire.
- BEQ x1,x2,-8 (0xFE208CE3) with alu_zero=1 → imm=-8, alu_op=010, pc_we=1, pc_branch=1. Repeat with alu_zero=0 → pc_branch=0.
- Illegal 0xFFFFFFFF → illegal pulses for 1 cycle and instr_ready returns. With the trap macro: illegal is held and instr_ready=0 until rst; rst asserted mid-LW forces all outputs to 0 immediately.
